seq_alu: RTL

//  Parametrised, multi-cycle successor to the 8-bit combinational datapath ALU.

---
 rtl/seq_alu.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle datapath ALU with valid/ready on both sides.
// Single-cycle ops finish on the accept edge. Shifts move one bit per edge.
// Multiply is shift-add, one multiplier bit per edge. The first iteration of an
// iterative op is done on the accept edge, so an op needing k steps shows
// out_valid after exactly k edges.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rslt,
   output logic             taken,
   output logic             carry
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LP_CNT_WIDTH = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] LP_CNT_WM1   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_PASS = 3'b000,
      OP_SHR  = 3'b001,
      OP_ADD  = 3'b010,
      OP_POS  = 3'b011,
      OP_XOR  = 3'b100,
      OP_BEQZ = 3'b101,
      OP_SHL  = 3'b110,
      OP_MUL  = 3'b111
   } op_e;

   state_e               r_state;
   logic [2:0]           r_op;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_acc;
   logic [2*WIDTH-1:0]   r_prod;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_rslt;
   logic                 r_taken;
   logic                 r_carry;

   logic                 w_idle;
   logic [2:0]           w_op;
   logic [CNT_W-1:0]     w_n;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH-1:0]     w_src_acc;
   logic [WIDTH-1:0]     w_acc_nxt;
   logic                 w_sc_nxt;
   logic [2*WIDTH-1:0]   w_src_prod;
   logic [2*WIDTH-1:0]   w_src_mcand;
   logic [WIDTH-1:0]     w_src_mplier;
   logic [2*WIDTH-1:0]   w_prod_nxt;
   logic [2*WIDTH-1:0]   w_mcand_nxt;
   logic [WIDTH-1:0]     w_mplier_nxt;
   logic                 w_mul_hi_nz;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign rslt      = r_rslt;
   assign taken     = r_taken;
   assign carry     = r_carry;

   // One iteration step: sourced from the ports on the accept edge, from the working registers while busy
   always_comb begin
      w_idle       = (r_state == S_IDLE);
      w_op         = w_idle ? op : r_op;
      w_n          = (in_b >= WIDTH'(WIDTH)) ? LP_CNT_WIDTH : in_b[CNT_W-1:0];
      w_sum        = {1'b0, in_a} + {1'b0, in_b};
      w_src_acc    = w_idle ? in_a : r_acc;
      w_acc_nxt    = {1'b0, w_src_acc[WIDTH-1:1]};
      w_sc_nxt     = w_src_acc[0];
      if (w_op == OP_SHL) begin
         w_acc_nxt = {w_src_acc[WIDTH-2:0], 1'b0};
         w_sc_nxt  = w_src_acc[WIDTH-1];
      end
      w_src_prod   = w_idle ? '0 : r_prod;
      w_src_mcand  = w_idle ? {{WIDTH{1'b0}}, in_a} : r_mcand;
      w_src_mplier = w_idle ? in_b : r_mplier;
      w_prod_nxt   = w_src_prod + (w_src_mplier[0] ? w_src_mcand : '0);
      w_mcand_nxt  = w_src_mcand << 1;
      w_mplier_nxt = w_src_mplier >> 1;
      w_mul_hi_nz  = |w_prod_nxt[2*WIDTH-1:WIDTH];
   end

   // Control FSM with registered result, flags and iteration state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_rslt   <= '0;
         r_taken  <= 1'b0;
         r_carry  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op    <= op;
                  r_taken <= 1'b0;
                  r_carry <= 1'b0;
                  r_state <= S_DONE;
                  case (op)
                     OP_PASS: r_rslt <= in_a;
                     OP_ADD: begin
                        r_rslt  <= w_sum[WIDTH-1:0];
                        r_carry <= w_sum[WIDTH];
                     end
                     OP_POS: begin
                        r_rslt  <= '0;
                        r_taken <= !in_a[WIDTH-1] && (in_a != '0);
                     end
                     OP_XOR: r_rslt <= in_a ^ in_b;
                     OP_BEQZ: begin
                        r_rslt  <= '0;
                        r_taken <= (in_a == '0);
                     end
                     OP_SHR, OP_SHL: begin
                        if (w_n == '0) begin
                           r_rslt <= in_a;
                        end else begin
                           r_acc <= w_acc_nxt;
                           r_cnt <= w_n - LP_CNT_ONE;
                           if (w_n == LP_CNT_ONE) begin
                              r_rslt  <= w_acc_nxt;
                              r_carry <= w_sc_nxt;
                           end else begin
                              r_state <= S_BUSY;
                           end
                        end
                     end
                     default: begin
                        r_prod   <= w_prod_nxt;
                        r_mcand  <= w_mcand_nxt;
                        r_mplier <= w_mplier_nxt;
                        r_cnt    <= LP_CNT_WM1;
                        r_state  <= S_BUSY;
                     end
                  endcase
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - LP_CNT_ONE;
               if (r_op == OP_MUL) begin
                  r_prod   <= w_prod_nxt;
                  r_mcand  <= w_mcand_nxt;
                  r_mplier <= w_mplier_nxt;
                  if (r_cnt == LP_CNT_ONE) begin
                     r_rslt  <= w_prod_nxt[WIDTH-1:0];
                     r_carry <= w_mul_hi_nz;
                     r_state <= S_DONE;
                  end
               end else begin
                  r_acc <= w_acc_nxt;
                  if (r_cnt == LP_CNT_ONE) begin
                     r_rslt  <= w_acc_nxt;
                     r_carry <= w_sc_nxt;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
